pc_next_ctrl: RTL and testbench

//  Next-PC sequencer sitting directly upstream of the 32-bit PC register.

---
 rtl/pc_next_ctrl.sv | 96 +++++++++
 tb/tb_pc_next_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pc_next_ctrl.sv
// Next-PC sequencer: drives the external PC register, issues fetches at
// pc_cur, advances on each fetch handshake, freezes on back-pressure and
// buffers branch redirects that arrive while no PC load is possible.
module pc_next_ctrl #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               INC          = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pc_cur,
  output logic [WIDTH-1:0] pc_next,
  output logic             pc_load,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic             stall,
  input  logic             branch_valid,
  input  logic [WIDTH-1:0] branch_target,
  output logic             redirect_pending
);

  typedef enum logic [1:0] {BOOT, REQ, HOLD} state_e;

  state_e           state_q, state_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;

  logic [WIDTH-1:0] tgt_al;
  logic [WIDTH-1:0] seq_pc;
  logic [WIDTH-1:0] redir_sel;

  // Loaded targets are word aligned; the sequential step wraps modulo 2^WIDTH.
  assign tgt_al    = branch_target & ~WIDTH'(3);
  assign seq_pc    = pc_cur + WIDTH'(INC);
  assign redir_sel = branch_valid ? tgt_al :
                     pend_q       ? pend_tgt_q : seq_pc;

  assign imem_addr        = pc_cur;
  assign redirect_pending = pend_q;

  // State and buffered-redirect registers; async clear drops any pending redirect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= BOOT;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  // Next state, PC load control, fetch request and redirect buffering.
  always_comb begin
    state_d    = state_q;
    pc_load    = 1'b0;
    pc_next    = redir_sel;
    imem_req   = 1'b0;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;

    unique case (state_q)
      BOOT: begin
        pc_load = 1'b1;
        pc_next = RESET_VECTOR;
        state_d = REQ;
      end
      REQ: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          if (stall) state_d = HOLD;
          else       pc_load = 1'b1;
        end
      end
      HOLD: begin
        if (!stall) begin
          pc_load = 1'b1;
          state_d = REQ;
        end
      end
      default: state_d = BOOT;
    endcase

    // A load consumes any redirect; otherwise the newest branch is kept.
    // Branches seen while booting are dropped (the boot load clears pend).
    if (pc_load) begin
      pend_d = 1'b0;
    end else if (branch_valid) begin
      pend_d     = 1'b1;
      pend_tgt_d = tgt_al;
    end
  end

endmodule

// File: tb/tb_pc_next_ctrl.sv
`timescale 1ns/100ps
// Bench for pc_next_ctrl: external PC register, directed scenarios with
// literal expectations, then randomized traffic against a reference model.
module tb_pc_next_ctrl;
  localparam logic [31:0] RV = 32'h100;

  logic        clk, reset;
  logic [31:0] pc_cur, pc_next, imem_addr, branch_target;
  logic        pc_load, imem_req, imem_ack, stall, branch_valid, redirect_pending;

  int total = 0;
  int bad   = 0;
  bit chk_on = 0;

  pc_next_ctrl #(.WIDTH(32), .RESET_VECTOR(RV), .INC(4)) dut (
    .clk(clk), .reset(reset), .pc_cur(pc_cur), .pc_next(pc_next),
    .pc_load(pc_load), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .stall(stall), .branch_valid(branch_valid),
    .branch_target(branch_target), .redirect_pending(redirect_pending)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // The PC register the sequencer feeds.
  always @(posedge clk) if (pc_load) pc_cur <= pc_next;

  // Reference model: where the sequencer is in the fetch lifecycle, the
  // remembered redirect, and what the PC ought to be.
  localparam int BOOTING = 0, FETCHING = 1, FROZEN = 2;
  int          m_ph   = BOOTING;
  bit          m_pend = 0;
  logic [31:0] m_tgt  = 0;
  logic [31:0] m_pc;

  function automatic void model_out(output bit req, output bit ld, output logic [31:0] nxt);
    logic [31:0] dest;
    if (branch_valid)  dest = {branch_target[31:2], 2'b00};
    else if (m_pend)   dest = m_tgt;
    else               dest = m_pc + 32'd4;
    req = (m_ph == FETCHING);
    if (m_ph == BOOTING)       begin ld = 1; nxt = RV; end
    else if (m_ph == FETCHING) begin ld = imem_ack && !stall; nxt = dest; end
    else                       begin ld = !stall; nxt = dest; end
  endfunction

  always @(posedge clk) begin
    bit r, l; logic [31:0] n;
    model_out(r, l, n);
    if (l) m_pc <= n;
  end

  always @(posedge clk or negedge reset) begin
    bit r, l; logic [31:0] n;
    if (!reset) begin
      m_ph <= BOOTING; m_pend <= 0; m_tgt <= 0;
    end else begin
      model_out(r, l, n);
      if (l) m_pend <= 0;
      else if (branch_valid && m_ph != BOOTING) begin
        m_pend <= 1; m_tgt <= {branch_target[31:2], 2'b00};
      end
      case (m_ph)
        BOOTING:  m_ph <= FETCHING;
        FETCHING: if (imem_ack && stall) m_ph <= FROZEN;
        default:  if (!stall) m_ph <= FETCHING;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT against the model every cycle, mid-cycle.
  always @(negedge clk) begin
    bit r, l; logic [31:0] n;
    if (chk_on) begin
      model_out(r, l, n);
      chk("m_req",  {31'b0, imem_req}, {31'b0, r});
      chk("m_addr", imem_addr, m_pc);
      chk("m_load", {31'b0, pc_load}, {31'b0, l});
      if (l) chk("m_next", pc_next, n);
      chk("m_pend", {31'b0, redirect_pending}, {31'b0, m_pend});
    end
  end

  task automatic cyc(input bit r, input bit a, input bit s, input bit bv, input logic [31:0] bt);
    @(posedge clk);
    #2;
    reset = r; imem_ack = a; stall = s; branch_valid = bv; branch_target = bt;
    #1;
  endtask

  initial begin
    reset = 0; imem_ack = 0; stall = 0; branch_valid = 0; branch_target = 0;
    // Reset held three cycles.
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1, 32'h777);
      chk_on = 1;
      chk("rst_req",  {31'b0, imem_req}, 32'd0);
      chk("rst_load", {31'b0, pc_load}, 32'd1);
      chk("rst_next", pc_next, 32'h100);
      chk("rst_pend", {31'b0, redirect_pending}, 32'd0);
    end
    cyc(1, 0, 0, 0, 0);
    // Zero-wait fetches.
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, 0, 0, 0);
      chk("seq_req",  {31'b0, imem_req}, 32'd1);
      chk("seq_addr", imem_addr, 32'h100 + 32'(4 * i));
    end
    // Ack withheld three cycles.
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0, 0);
      chk("wait_addr", imem_addr, 32'h110);
      chk("wait_load", {31'b0, pc_load}, 32'd0);
    end
    cyc(1, 1, 0, 0, 0);
    chk("wait_next", pc_next, 32'h114);
    // Two redirects while waiting; newest wins.
    cyc(1, 0, 0, 1, 32'h203);
    cyc(1, 0, 0, 0, 0);
    chk("br_pend", {31'b0, redirect_pending}, 32'd1);
    cyc(1, 0, 0, 1, 32'h300);
    cyc(1, 1, 0, 0, 0);
    chk("br_next", pc_next, 32'h300);
    cyc(1, 0, 0, 0, 0);
    chk("br_clr",  {31'b0, redirect_pending}, 32'd0);
    chk("br_addr", imem_addr, 32'h300);
    // Stall into HOLD with a branch arriving there.
    cyc(1, 1, 1, 0, 0);
    chk("hold_load", {31'b0, pc_load}, 32'd0);
    cyc(1, 0, 1, 1, 32'h400);
    chk("hold_req",  {31'b0, imem_req}, 32'd0);
    chk("hold_addr", imem_addr, 32'h300);
    cyc(1, 0, 1, 0, 0);
    chk("hold_pend", {31'b0, redirect_pending}, 32'd1);
    cyc(1, 0, 0, 0, 0);
    chk("hold_next", pc_next, 32'h400);
    chk("hold_ld",   {31'b0, pc_load}, 32'd1);
    // Wraparound, then async reset mid-fetch with a redirect pending.
    cyc(1, 0, 0, 1, 32'hFFFF_FFFC);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    chk("wrap_next", pc_next, 32'h0);
    cyc(1, 0, 0, 1, 32'h501);
    cyc(1, 0, 0, 0, 0);
    chk("pre_rst_pend", {31'b0, redirect_pending}, 32'd1);
    reset = 0;
    #1;
    chk("async_req",  {31'b0, imem_req}, 32'd0);
    chk("async_pend", {31'b0, redirect_pending}, 32'd0);
    chk("async_next", pc_next, 32'h100);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    // Randomized traffic, with occasional reset pulses.
    for (int i = 0; i < 600; i++)
      cyc(($urandom_range(99) == 0) ? 1'b0 : 1'b1,
          $urandom_range(9) < 7, $urandom_range(9) < 3,
          $urandom_range(99) < 15, $urandom());
    @(posedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
